// File: rtl/rx_engine_ctrl.sv
// UART RX sequencer: start detect, mid-cell sampling into o_sr, status latch from the remap result.
// Latency ~(NB+0.5)*i_k + SYNC_STAGES + 3 clocks; no backpressure, a character not read in time sets o_ovf.
module rx_engine_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rx,
   input  logic [18:0] i_k,
   input  logic        i_eight,
   input  logic        i_pen,
   input  logic        i_ohel,
   input  logic        i_read,
   output logic [9:0]  o_sr,
   input  logic [9:0]  i_remap,
   output logic [7:0]  o_data,
   output logic        o_rxrdy,
   output logic        o_perr,
   output logic        o_ferr,
   output logic        o_ovf
);

   typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [18:0]            cnt_q, cnt_d;
   logic [3:0]             bit_q, bit_d;
   logic [9:0]             sr_q, sr_d;
   logic [7:0]             data_q, data_d;
   logic                   rxrdy_q, rxrdy_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ovf_q, ovf_d;
   logic                   eight_q, eight_d;
   logic                   pen_q, pen_d;
   logic                   ohel_q, ohel_d;

   logic                   rx_s;
   logic [3:0]             nb;
   logic [3:0]             bit_inc;

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign nb      = 4'd8 + {3'b000, eight_q} + {3'b000, pen_q};
   assign bit_inc = bit_q + 4'd1;
   assign sync_d  = {sync_q[SYNC_STAGES-2:0], i_rx};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      data_d  = data_q;
      rxrdy_d = rxrdy_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovf_d   = ovf_q;
      eight_d = eight_q;
      pen_d   = pen_q;
      ohel_d  = ohel_q;

      // A read clears status; a DONE in the same cycle overrides below.
      if (i_read) begin
         rxrdy_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
         ovf_d   = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rx_s) begin
               state_d = START;
               eight_d = i_eight;
               pen_d   = i_pen;
               ohel_d  = i_ohel;
            end
         end
         START: begin
            if (cnt_q == (i_k >> 1)) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
               sr_d    = rx_s ? sr_q : 10'h3FF;
            end else begin
               cnt_d = cnt_q + 19'd1;
            end
         end
         DATA: begin
            if (cnt_q == i_k - 19'd1) begin
               cnt_d = '0;
               sr_d  = {rx_s, sr_q[9:1]};
               bit_d = bit_inc;
               if (bit_inc == nb) state_d = DONE;
            end else begin
               cnt_d = cnt_q + 19'd1;
            end
         end
         DONE: begin
            data_d  = i_remap[7:0];
            ferr_d  = ~i_remap[9];
            perr_d  = pen_q & ((^i_remap[8:0]) ^ ohel_q);
            ovf_d   = ovf_q | (rxrdy_q & ~i_read);
            rxrdy_d = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         sync_q  <= '1;
         cnt_q   <= '0;
         bit_q   <= '0;
         sr_q    <= 10'h3FF;
         data_q  <= '0;
         rxrdy_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         eight_q <= 1'b0;
         pen_q   <= 1'b0;
         ohel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         rxrdy_q <= rxrdy_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovf_q   <= ovf_d;
         eight_q <= eight_d;
         pen_q   <= pen_d;
         ohel_q  <= ohel_d;
      end
   end

   assign o_sr    = sr_q;
   assign o_data  = data_q;
   assign o_rxrdy = rxrdy_q;
   assign o_perr  = perr_q;
   assign o_ferr  = ferr_q;
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_rx_engine_ctrl.sv
// Bench for rx_engine_ctrl: serial frames from a character-level model, scoreboard checked on o_rxrdy rise.
module tb_rx_engine_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic [18:0] k;
   logic        eight, pen, ohel;
   logic        rd;
   logic [9:0]  sr, remap;
   logic [7:0]  data;
   logic        rxrdy, perr, ferr, ovf;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t expq[$];
   exp_t e;
   logic rxrdy_prev = 1'b0;

   always #5 clk = ~clk;

   rx_engine_ctrl #(.SYNC_STAGES(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_rx    (rx),
      .i_k     (k),
      .i_eight (eight),
      .i_pen   (pen),
      .i_ohel  (ohel),
      .i_read  (rd),
      .o_sr    (sr),
      .i_remap (remap),
      .o_data  (data),
      .o_rxrdy (rxrdy),
      .o_perr  (perr),
      .o_ferr  (ferr),
      .o_ovf   (ovf)
   );

   // Model of the external remap block: right-justify the frame held in sr[9:10-NB].
   function automatic logic [9:0] remap_f(input logic [9:0] s, input logic e8, input logic p);
      int nbits, dbits;
      logic [9:0] fr, r;
      nbits = 8 + int'(e8) + int'(p);
      dbits = 7 + int'(e8);
      fr = s >> (10 - nbits);
      r = '0;
      for (int i = 0; i < dbits; i++) r[i] = fr[i];
      r[8] = p ? fr[dbits] : 1'b1;
      r[9] = fr[nbits-1];
      return r;
   endfunction

   assign remap = remap_f(sr, eight, pen);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every new character announcement pops one expectation.
   always @(negedge clk) begin
      if (rxrdy && !rxrdy_prev) begin
         if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rxrdy: got data %0h, required no character", data);
         end else begin
            e = expq.pop_front();
            check("mon_data", {24'd0, data}, {24'd0, e.data});
            check("mon_perr", {31'd0, perr}, {31'd0, e.perr});
            check("mon_ferr", {31'd0, ferr}, {31'd0, e.ferr});
            check("mon_ovf",  {31'd0, ovf},  32'd0);
         end
      end
      rxrdy_prev = rxrdy;
   end

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int gap);
      logic [10:0] bits;
      int n;
      bits = '0;
      n = 1;
      for (int i = 0; i < 7 + int'(eight); i++) begin
         bits[n] = d[i];
         n++;
      end
      if (pen) begin
         bits[n] = par;
         n++;
      end
      bits[n] = stop;
      n++;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         #1 rx = bits[i];
         repeat (k) @(posedge clk);
      end
      #1 rx = 1'b1;
      repeat (gap) @(posedge clk);
   endtask

   task automatic wait_consumed();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (expq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL rxrdy_timeout: %0d characters pending, required 0", expq.size());
         expq.delete();
      end
   endtask

   task automatic read_and_check();
      @(posedge clk);
      #1 rd = 1'b1;
      @(posedge clk);
      #1 rd = 1'b0;
      check("read_clear", {28'd0, rxrdy, perr, ferr, ovf}, 32'd0);
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
      exp_t x;
      logic [7:0] dm;
      int ones;
      dm = eight ? d : {1'b0, d[6:0]};
      ones = $countones(dm) + int'(par);
      x.data = dm;
      x.perr = pen && ((ones % 2) != int'(ohel));
      x.ferr = !stop;
      expq.push_back(x);
      send_frame(d, par, stop, 2 * int'(k) + $urandom_range(0, 8));
      wait_consumed();
      read_and_check();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       par, stop;
      int         h, nbits;

      rst_n = 1'b0;
      rx    = 1'b1;
      rd    = 1'b0;
      k     = 19'd16;
      eight = 1'b1;
      pen   = 1'b0;
      ohel  = 1'b0;
      #12;
      check("rst_sr",    {22'd0, sr}, 32'h3FF);
      check("rst_data",  {24'd0, data}, 32'd0);
      check("rst_flags", {28'd0, rxrdy, perr, ferr, ovf}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Glitch shorter than half a bit is a false start.
      #1 rx = 1'b0;
      repeat (5) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("glitch_rxrdy", {31'd0, rxrdy}, 32'd0);
      check("glitch_sr",    {22'd0, sr}, 32'h3FF);

      // 8N1 0xA5
      expect_frame(8'hA5, 1'b1, 1'b1);

      // 7E1 0x41 with good then bad parity
      eight = 1'b0; pen = 1'b1; ohel = 1'b0;
      expect_frame(8'h41, 1'b0, 1'b1);
      expect_frame(8'h41, 1'b1, 1'b1);

      // 8O1 0x00, parity 1, stop 0
      eight = 1'b1; pen = 1'b1; ohel = 1'b1;
      expect_frame(8'h00, 1'b1, 1'b0);

      // Overrun: second character arrives while the first is unread.
      eight = 1'b1; pen = 1'b0; ohel = 1'b0;
      expq.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
      send_frame(8'h11, 1'b1, 1'b1, 40);
      wait_consumed();
      send_frame(8'h22, 1'b1, 1'b1, 40);
      #1;
      check("ovr_data",  {24'd0, data}, 32'h22);
      check("ovr_ovf",   {31'd0, ovf}, 32'd1);
      check("ovr_rxrdy", {31'd0, rxrdy}, 32'd1);
      read_and_check();

      // Same, but the read lands in the DONE cycle of the second character.
      expq.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
      send_frame(8'h11, 1'b1, 1'b1, 40);
      wait_consumed();
      h = int'(k) / 2;
      nbits = 8 + int'(eight) + int'(pen);
      fork
         send_frame(8'h22, 1'b1, 1'b1, 40);
         begin
            @(posedge clk);
            repeat (4 + h + nbits * int'(k)) @(posedge clk);
            #1 rd = 1'b1;
            @(posedge clk);
            #1 rd = 1'b0;
         end
      join
      #1;
      check("rdone_data",  {24'd0, data}, 32'h22);
      check("rdone_ovf",   {31'd0, ovf}, 32'd0);
      check("rdone_rxrdy", {31'd0, rxrdy}, 32'd1);
      read_and_check();

      // Reset in the middle of the data bits.
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (3 * int'(k)) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_rxrdy", {31'd0, rxrdy}, 32'd0);
      check("midrst_sr",    {22'd0, sr}, 32'h3FF);
      rx = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      expect_frame(8'h5A, 1'b1, 1'b1);

      // Randomized frames across bit times and formats.
      for (int i = 0; i < 16; i++) begin
         k     = 19'($urandom_range(4, 24));
         eight = 1'($urandom_range(0, 1));
         pen   = 1'($urandom_range(0, 1));
         ohel  = 1'($urandom_range(0, 1));
         d     = 8'($urandom_range(0, 255));
         par   = 1'(($countones(eight ? d : {1'b0, d[6:0]}) % 2) ^ int'(ohel));
         if ($urandom_range(0, 3) == 0) par = ~par;
         stop  = ($urandom_range(0, 4) != 0);
         expect_frame(d, par, stop);
      end

      repeat (10) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rx_engine_ctrl.md
Name: rx_engine_ctrl

Overview:
- UART receive sequencer for the RX engine.
- Detects the start bit and times bit cells from the baud count `i_k`, shifting serial bits into a 10-bit shift register.
- Presents the shift register to the existing RX remap block and latches its aligned output.
- Generates the RXRDY, parity-error, framing-error and overflow status consumed by the TSI/processor read path.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising i_rx (minimum 2).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx  in  1  asynchronous serial line; idles high.
- i_k  in  19  clocks per bit time; legal range ≥4.
- i_eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- i_pen  in  1  parity enable.
- i_ohel  in  1  parity select: 1 = odd, 0 = even.
- i_read  in  1  one-cycle pulse; clears o_rxrdy and all error flags.
- o_sr  out  10  shift-register contents, driven to the remap block's i_data.
- i_remap  in  10  remap block output: [7:0] data (bit7 = 0 when 7-bit), [8] parity bit, [9] stop bit.
- o_data  out  8  received character.
- o_rxrdy  out  1  character available.
- o_perr  out  1  parity error.
- o_ferr  out  1  framing error (stop bit sampled 0).
- o_ovf  out  1  overrun (new character arrived while o_rxrdy was still set).

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE; o_sr = 10'h3FF; o_data = 0.
  - o_rxrdy = o_perr = o_ferr = o_ovf = 0.
  - Bit-time counter = 0; bit counter = 0.
- Reset mid-frame discards the partial frame.
- rx_s is the synchronised i_rx; all decisions use rx_s only.
- Frame length after the start bit: NB = 8 + i_eight + i_pen (8, 9 or 10 sampled bits, stop bit included).
- i_eight, i_pen and i_ohel are sampled into internal registers on the IDLE→START transition and held for the whole frame.
- IDLE:
  - Counters held at 0.
  - rx_s == 0 → START; bit-time counter cleared.
- START:
  - Bit-time counter increments each clock.
  - When count == i_k>>1 (mid start bit): if rx_s == 0, go to DATA and clear the counter; otherwise false start, go to IDLE.
- DATA:
  - Counter increments each clock.
  - When count == i_k-1 (one full bit time later, i.e. mid-cell):
    - o_sr <= {rx_s, o_sr[9:1]}.
    - Bit counter increments; bit-time counter clears.
  - When the bit counter reaches NB after the shift → DONE.
  - o_sr is preset to 10'h3FF on entry to DATA. After NB shifts, the frame occupies o_sr[9:10-NB], LSB first; the remap block right-justifies it.
- DONE (exactly one clock):
  - o_data <= i_remap[7:0].
  - o_ferr <= ~i_remap[9].
  - o_perr <= i_pen & (^{data bits, i_remap[8]} ^ i_ohel). The XOR over the data bits plus the parity bit must be 0 for even parity and 1 for odd parity; any other result flags an error.
  - o_ovf <= o_ovf | (o_rxrdy & ~i_read).
  - o_rxrdy <= 1.
  - Next state is IDLE. A new start bit is recognised no earlier than the clock after DONE.
  - Error flags are sticky across frames until read, except that o_perr and o_ferr are overwritten at each DONE.
- i_read:
  - In a non-DONE cycle, clears o_rxrdy, o_perr, o_ferr and o_ovf on the next edge.
  - Simultaneous with DONE: the new character wins, so o_rxrdy = 1, new flags are loaded, and o_ovf is not set by this event.
- Latency: o_rxrdy rises (NB + 0.5) × i_k + SYNC_STAGES + 2 clocks (±1) after the i_rx falling edge.
- The line is not sampled in DONE. A break (rx held 0) therefore yields data 0 with o_ferr = 1, then a new START as soon as IDLE sees rx_s == 0.

Test Plan:
- i_k=16, 8N1 (i_eight=1, i_pen=0), send 0xA5, stop=1 → o_rxrdy rises; o_data=8'hA5, o_perr=0, o_ferr=0. i_read pulse → o_rxrdy=0 next clock.
- i_k=16, 7E1 (i_eight=0, i_pen=1, i_ohel=0), send 0x41 with parity 0 → o_data=8'h41, o_perr=0. Repeat with parity 1 → o_perr=1.
- i_k=16, 8O1, send 0x00 with stop bit = 0 → o_data=8'h00, o_ferr=1; o_perr=0 since the parity bit is 1.
- Glitch test: i_rx low for 5 clocks (< i_k/2) then high → returns to IDLE; o_rxrdy stays 0 and o_sr stays 10'h3FF.
- Overrun: receive 0x11 then 0x22 without i_read → o_data=8'h22, o_ovf=1. Repeat with i_read asserted in the DONE cycle of the second frame → o_ovf=0, o_rxrdy=1.
- Assert i_rst_n=0 midway through a frame's data bits, release, then send 0x5A → no spurious rxrdy during reset; 0x5A is received correctly.
